// File: rtl/strobe_run_receiver_if.sv
// strobe_run_receiver_if
//   Single-bit strobe interface.
//   en : strobe, high while a run is in progress.
//   Modports: port (driver side, drives en), mon (observer side, reads en).
interface strobe_run_receiver_if;
   logic en;
   modport port (output en);
   modport mon  (input  en);
endinterface

// File: rtl/strobe_run_receiver.sv
// strobe_run_receiver
//   Measures the length of each high run of the strobe b.en, queues completed
//   run lengths in a DEPTH-entry FIFO with a valid/ready output, counts rising
//   edges and flags dropped runs.
// Ports:
//   i_clk          clock, rising edge
//   i_rst          synchronous reset, active low
//   b              strobe interface, monitor modport (en)
//   i_clear        synchronous soft clear of FIFO, run state, counters, flag
//   o_valid        FIFO head entry available
//   i_ready        consumer accepts the head entry
//   o_len          run length at FIFO head, 0 when empty (saturates)
//   o_busy         a run is being measured
//   o_pulse_count  rising edges seen, wraps modulo 2^16
//   o_overflow     sticky, a completed run was dropped on a full FIFO
module strobe_run_receiver #(
   parameter int LEN_W = 8,
   parameter int DEPTH = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   strobe_run_receiver_if.mon   b,
   input  logic                 i_clear,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic [LEN_W-1:0]     o_len,
   output logic                 o_busy,
   output logic [15:0]          o_pulse_count,
   output logic                 o_overflow
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW:0]      FULL_CNT = (PW+1)'(DEPTH);
   localparam logic [LEN_W-1:0] LEN_MAX  = {LEN_W{1'b1}};

   logic              en_q;
   logic              active_q, active_d;
   logic [LEN_W-1:0]  run_q, run_d;
   logic [15:0]       pulse_q, pulse_d;
   logic              ovf_q, ovf_d;
   logic [PW-1:0]     rd_q, rd_d, wr_q, wr_d;
   logic [PW:0]       cnt_q, cnt_d;
   logic [LEN_W-1:0]  mem_q [DEPTH];

   logic rise, hold, fall, full, pop, push_ok;

   // Edge detection uses the live strobe against its registered copy, so
   // a run is seen at the same edge that first samples en high.
   assign rise = b.en & ~en_q;
   assign hold = b.en &  en_q & active_q;
   assign fall = ~b.en & en_q & active_q;

   assign full    = (cnt_q == FULL_CNT);
   assign pop     = (cnt_q != '0) & i_ready;
   // A push into a full FIFO only lands when the head leaves in the same cycle.
   assign push_ok = fall & (~full | pop);

   always_comb begin
      active_d = active_q;
      run_d    = run_q;
      pulse_d  = pulse_q;
      ovf_d    = ovf_q;
      rd_d     = rd_q;
      wr_d     = wr_q;
      cnt_d    = cnt_q;
      if (i_clear) begin
         active_d = 1'b0;
         run_d    = '0;
         pulse_d  = '0;
         ovf_d    = 1'b0;
         rd_d     = '0;
         wr_d     = '0;
         cnt_d    = '0;
      end else begin
         if (rise) begin
            run_d    = LEN_W'(1);
            active_d = 1'b1;
            pulse_d  = pulse_q + 16'd1;
         end else if (hold) begin
            run_d = (run_q == LEN_MAX) ? LEN_MAX : run_q + 1'b1;
         end else if (fall) begin
            active_d = 1'b0;
         end
         if (fall & ~push_ok) ovf_d = 1'b1;
         if (pop)     rd_d = rd_q + 1'b1;
         if (push_ok) wr_d = wr_q + 1'b1;
         case ({push_ok, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         en_q     <= 1'b0;
         active_q <= 1'b0;
         run_q    <= '0;
         pulse_q  <= '0;
         ovf_q    <= 1'b0;
         rd_q     <= '0;
         wr_q     <= '0;
         cnt_q    <= '0;
      end else begin
         en_q     <= b.en;   // clear leaves the strobe history intact
         active_q <= active_d;
         run_q    <= run_d;
         pulse_q  <= pulse_d;
         ovf_q    <= ovf_d;
         rd_q     <= rd_d;
         wr_q     <= wr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage needs no reset; entries are only read while counted valid.
   always_ff @(posedge i_clk) begin
      if (i_rst && !i_clear && push_ok) mem_q[wr_q] <= run_q;
   end

   assign o_valid       = (cnt_q != '0);
   assign o_len         = o_valid ? mem_q[rd_q] : '0;
   assign o_busy        = active_q;
   assign o_pulse_count = pulse_q;
   assign o_overflow    = ovf_q;
endmodule

// File: tb/tb_strobe_run_receiver.sv
module tb_strobe_run_receiver;
   localparam int LEN_W = 4;
   localparam int DEPTH = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             clr;
   logic             rdy;
   logic             valid;
   logic [LEN_W-1:0] len;
   logic             busy;
   logic [15:0]      pcnt;
   logic             ovf;

   int tests = 0;
   int fails = 0;
   int sb[$];

   strobe_run_receiver_if b ();

   strobe_run_receiver #(.LEN_W(LEN_W), .DEPTH(DEPTH)) dut (
      .i_clk(clk), .i_rst(rst_n), .b(b), .i_clear(clr),
      .o_valid(valid), .i_ready(rdy), .o_len(len), .o_busy(busy),
      .o_pulse_count(pcnt), .o_overflow(ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: every accepted beat is compared against the scoreboard head.
   always @(negedge clk) begin
      if (rst_n && !clr && valid && rdy) begin
         tests++;
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL beat: unexpected o_len=%0d with empty scoreboard", len);
         end else begin
            int e;
            e = sb.pop_front();
            if (int'(len) != e) begin
               fails++;
               $display("FAIL beat: got o_len=%0d expected %0d", len, e);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "timeout");
   end

   task automatic step(input logic e, input logic r);
      b.en = e;
      rdy  = r;
      @(posedge clk);
      #1;
   endtask

   // Run of n high cycles followed by one low cycle; expected length queued.
   task automatic run(input int n, input logic r, input bit push);
      for (int i = 0; i < n; i++) step(1'b1, r);
      step(1'b0, r);
      if (push) sb.push_back((n > 15) ? 15 : n);
   endtask

   task automatic do_clear(input logic e);
      clr = 1'b1;
      sb.delete();
      step(e, 1'b0);
      clr = 1'b0;
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b1);
   endtask

   initial begin
      rst_n = 1'b0; clr = 1'b0; rdy = 1'b0; b.en = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset valid", valid, 0);
      chk("reset len", len, 0);
      chk("reset busy", busy, 0);
      chk("reset pulse", pcnt, 0);
      chk("reset ovf", ovf, 0);
      rst_n = 1'b1;

      // Single run of 5
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 1'b1);
         chk("single busy", busy, 1);
      end
      step(1'b0, 1'b1);
      sb.push_back(5);
      chk("single busy end", busy, 0);
      chk("single valid", valid, 1);
      chk("single len", len, 5);
      chk("single pulse", pcnt, 1);
      drain(1);
      chk("single ovf", ovf, 0);
      chk("single empty", valid, 0);

      // Saturation: 20 cycles on a 4-bit counter
      run(20, 1'b1, 1'b1);
      chk("sat len", len, 15);
      drain(1);

      // Minimum length and back-to-back runs
      run(1, 1'b1, 1'b1);
      run(2, 1'b1, 1'b1);
      drain(1);

      // Full and overflow
      do_clear(1'b0);
      run(1, 1'b0, 1'b1);
      run(2, 1'b0, 1'b1);
      run(3, 1'b0, 1'b1);
      run(4, 1'b0, 1'b1);
      chk("full ovf before", ovf, 0);
      run(5, 1'b0, 1'b0);
      chk("full ovf after", ovf, 1);
      chk("full head", len, 1);
      drain(4);
      chk("drain empty", valid, 0);
      chk("drain len zero", len, 0);
      chk("ovf sticky", ovf, 1);

      // Push and pop on a full FIFO
      do_clear(1'b0);
      chk("clear ovf", ovf, 0);
      run(1, 1'b0, 1'b1);
      run(2, 1'b0, 1'b1);
      run(3, 1'b0, 1'b1);
      run(4, 1'b0, 1'b1);
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
      step(1'b0, 1'b1);
      sb.push_back(6);
      chk("pp ovf", ovf, 0);
      chk("pp valid", valid, 1);
      chk("pp head", len, 2);
      drain(4);
      chk("pp empty", valid, 0);

      // Clear mid-run
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
      do_clear(1'b1);
      chk("clr busy", busy, 0);
      chk("clr pulse", pcnt, 0);
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      chk("clr busy held", busy, 0);
      step(1'b0, 1'b1);
      chk("clr no push", valid, 0);
      run(2, 1'b1, 1'b1);
      chk("clr run len", len, 2);
      chk("clr run pulse", pcnt, 1);
      drain(1);

      // Reset mid-run
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      rst_n = 1'b0;
      sb.delete();
      step(1'b1, 1'b1);
      rst_n = 1'b1;
      chk("rst busy", busy, 0);
      chk("rst pulse", pcnt, 0);
      run(3, 1'b1, 1'b1);
      chk("rst len", len, 3);
      chk("rst pulse after", pcnt, 1);
      drain(1);

      // Pulse count across the 8-bit boundary
      do_clear(1'b0);
      for (int i = 0; i < 300; i++) run(1, 1'b1, 1'b1);
      drain(1);
      chk("pulse 300", pcnt, 300);
      chk("pulse ovf", ovf, 0);

      chk("scoreboard empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
